// File: rtl/rf_pkg.sv
// Shared constants and the write-back request type for the register-file write path.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_IDX_W  = 5;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at commit, flushed on kill.
// Drives the read-after-write stall toward decode.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_rd,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_rd,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  output logic                 hazard,
  output logic [NREG-1:0]      busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Order matters: a same-edge set beats a clear (newer producer in flight),
  // and flush beats everything.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0)) busy_d[set_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy   = busy_q;
  assign hazard = (rs1_used & busy_q[rs1]) | (rs2_used & busy_q[rs2]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port (link > load > ALU,
// with an ALU anti-starvation override) plus the busy scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int NREG       = rf_pkg::NREG,
  parameter int STARVE_MAX = rf_pkg::STARVE_MAX
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         alu_valid_i,
  input  logic [rf_pkg::REG_IDX_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]              alu_data_i,
  output logic                         alu_ready_o,
  input  logic                         ld_valid_i,
  input  logic [rf_pkg::REG_IDX_W-1:0] ld_rd_i,
  input  logic [XLEN-1:0]              ld_data_i,
  output logic                         ld_ready_o,
  input  logic                         lnk_valid_i,
  input  logic [rf_pkg::REG_IDX_W-1:0] lnk_rd_i,
  input  logic [XLEN-1:0]              lnk_data_i,
  output logic                         lnk_ready_o,
  input  logic                         issue_valid_i,
  input  logic [rf_pkg::REG_IDX_W-1:0] issue_rd_i,
  input  logic [rf_pkg::REG_IDX_W-1:0] rs1_i,
  input  logic [rf_pkg::REG_IDX_W-1:0] rs2_i,
  input  logic                         rs1_used_i,
  input  logic                         rs2_used_i,
  input  logic                         flush_i,
  output logic                         hazard_o,
  output logic                         rwr_en_o,
  output logic [rf_pkg::REG_IDX_W-1:0] rd_o,
  output logic [XLEN-1:0]              wr_o,
  output logic [NREG-1:0]              busy_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  // Handshake: a producer holds valid/rd/data until ready; transfer = valid & ready.
  // At most one ready is high per cycle and never without its valid.
  rf_pkg::wb_req_t alu_req, ld_req, lnk_req, win;
  logic [CW-1:0]   starve_cnt, starve_nxt;
  logic            force_alu;
  logic            xfer;

  assign alu_req = '{valid: alu_valid_i, rd: alu_rd_i, data: alu_data_i};
  assign ld_req  = '{valid: ld_valid_i,  rd: ld_rd_i,  data: ld_data_i};
  assign lnk_req = '{valid: lnk_valid_i, rd: lnk_rd_i, data: lnk_data_i};

  always_comb begin
    alu_ready_o = 1'b0;
    ld_ready_o  = 1'b0;
    lnk_ready_o = 1'b0;
    win         = '0;
    force_alu   = alu_req.valid && (starve_cnt == CW'(STARVE_MAX));
    if (rst_ni) begin
      if (force_alu) begin
        alu_ready_o = 1'b1;
        win         = alu_req;
      end else if (lnk_req.valid) begin
        lnk_ready_o = 1'b1;
        win         = lnk_req;
      end else if (ld_req.valid) begin
        ld_ready_o  = 1'b1;
        win         = ld_req;
      end else if (alu_req.valid) begin
        alu_ready_o = 1'b1;
        win         = alu_req;
      end
    end
  end

  assign xfer = alu_ready_o | ld_ready_o | lnk_ready_o;

  always_comb begin
    starve_nxt = starve_cnt;
    if (!alu_valid_i || alu_ready_o)            starve_nxt = '0;
    else if (starve_cnt != CW'(STARVE_MAX))     starve_nxt = starve_cnt + 1'b1;
  end

  // x0 requests are accepted but never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rwr_en_o   <= 1'b0;
      rd_o       <= '0;
      wr_o       <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      rwr_en_o   <= xfer && (win.rd != '0);
      if (xfer) begin
        rd_o <= win.rd;
        wr_o <= win.data;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .set_en   (issue_valid_i),
    .set_rd   (issue_rd_i),
    .clr_en   (rwr_en_o),
    .clr_rd   (rd_o),
    .flush    (flush_i),
    .rs1      (rs1_i),
    .rs2      (rs2_i),
    .rs1_used (rs1_used_i),
    .rs2_used (rs2_used_i),
    .hazard   (hazard_o),
    .busy     (busy_o)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus random checks of rf_wb_arbiter against a rule-level reference model.
module tb_rf_wb_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alu_valid_i, ld_valid_i, lnk_valid_i;
  logic [4:0]  alu_rd_i, ld_rd_i, lnk_rd_i;
  logic [31:0] alu_data_i, ld_data_i, lnk_data_i;
  logic        alu_ready_o, ld_ready_o, lnk_ready_o;
  logic        issue_valid_i, flush_i;
  logic [4:0]  issue_rd_i, rs1_i, rs2_i;
  logic        rs1_used_i, rs2_used_i;
  logic        hazard_o, rwr_en_o;
  logic [4:0]  rd_o;
  logic [31:0] wr_o;
  logic [31:0] busy_o;

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_MAX(STARVE)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .lnk_valid_i(lnk_valid_i), .lnk_rd_i(lnk_rd_i), .lnk_data_i(lnk_data_i), .lnk_ready_o(lnk_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .flush_i(flush_i), .hazard_o(hazard_o), .rwr_en_o(rwr_en_o), .rd_o(rd_o), .wr_o(wr_o),
    .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_cnt;
  bit [31:0]   m_busy;
  bit          m_wen;
  bit          hold_ld;
  logic [36:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_valid_i = 0; ld_valid_i = 0; lnk_valid_i = 0;
    alu_rd_i = 0; ld_rd_i = 0; lnk_rd_i = 0;
    alu_data_i = 0; ld_data_i = 0; lnk_data_i = 0;
    issue_valid_i = 0; issue_rd_i = 0; flush_i = 0;
    rs1_i = 0; rs2_i = 0; rs1_used_i = 0; rs2_used_i = 0;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_busy = '0; m_wen = 0;
    exp_q.delete();
  endtask

  // One clock of traffic: check combinational outputs, advance the model across
  // the edge, check registered outputs, then drop the granted producer's valid.
  task automatic cycle();
    int          win;
    bit [31:0]   nb;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    #1;
    win = 0;
    if (alu_valid_i && m_cnt == STARVE) win = 1;
    else if (lnk_valid_i)               win = 3;
    else if (ld_valid_i)                win = 2;
    else if (alu_valid_i)               win = 1;
    chk("alu_ready", alu_ready_o, win == 1);
    chk("ld_ready",  ld_ready_o,  win == 2);
    chk("lnk_ready", lnk_ready_o, win == 3);
    chk("hazard", hazard_o, (rs1_used_i && m_busy[rs1_i]) || (rs2_used_i && m_busy[rs2_i]));
    chk("busy", busy_o, m_busy);
    wrd = 0; wdat = 0;
    case (win)
      1: begin wrd = alu_rd_i; wdat = alu_data_i; end
      2: begin wrd = ld_rd_i;  wdat = ld_data_i;  end
      3: begin wrd = lnk_rd_i; wdat = lnk_data_i; end
      default: ;
    endcase
    nb = m_busy;
    if (m_wen) nb[rd_o] = 1'b0;
    if (issue_valid_i && issue_rd_i != 0) nb[issue_rd_i] = 1'b1;
    if (flush_i) nb = '0;
    if (win == 1 || !alu_valid_i) m_cnt = 0;
    else if (m_cnt < STARVE)      m_cnt = m_cnt + 1;
    if (win != 0 && wrd != 0) exp_q.push_back({wrd, wdat});
    @(posedge clk); #1;
    m_busy = nb;
    m_wen  = (win != 0 && wrd != 0);
    chk("rwr_en", rwr_en_o, m_wen);
    if (m_wen && exp_q.size() > 0) chk("write", {rd_o, wr_o}, exp_q.pop_front());
    if (win == 1) alu_valid_i = 0;
    if (win == 2 && !hold_ld) ld_valid_i = 0;
    if (win == 3) lnk_valid_i = 0;
  endtask

  initial begin
    clear_inputs();
    hold_ld = 0;
    model_reset();

    // reset state, with a request present to show readies are held low
    rst_ni = 0;
    alu_valid_i = 1; alu_rd_i = 3;
    rs1_i = 1; rs1_used_i = 1;
    #2;
    chk("rst_rwr_en", rwr_en_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_wr", wr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_alu_ready", alu_ready_o, 0);
    chk("rst_hazard", hazard_o, 0);
    @(posedge clk); @(posedge clk); #1;
    clear_inputs();
    rst_ni = 1;

    // single ALU write
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEAD_BEEF;
    cycle(); cycle();

    // all three at once: lnk, ld, alu in order
    lnk_valid_i = 1; lnk_rd_i = 1; lnk_data_i = 32'h0000_1111;
    ld_valid_i  = 1; ld_rd_i  = 2; ld_data_i  = 32'h0000_2222;
    alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h0000_3333;
    repeat (4) cycle();

    // starvation: ld held, alu forced through after STARVE losses
    hold_ld = 1;
    ld_valid_i = 1; ld_rd_i = 7; ld_data_i = 32'h7777_0000;
    alu_valid_i = 1; alu_rd_i = 8; alu_data_i = 32'h8888_0000;
    repeat (STARVE + 1) cycle();
    alu_valid_i = 1;
    cycle();
    hold_ld = 0; clear_inputs();
    cycle();

    // RAW hazard on x9
    issue_valid_i = 1; issue_rd_i = 9; rs1_i = 9; rs1_used_i = 1;
    cycle();
    issue_valid_i = 0;
    cycle();
    alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 32'h9999_9999;
    repeat (3) cycle();
    issue_valid_i = 1;
    cycle();
    issue_valid_i = 0; rs1_used_i = 0;
    cycle();
    flush_i = 1; cycle(); flush_i = 0;

    // same-edge set and commit on x4, then flush
    alu_valid_i = 1; alu_rd_i = 4; alu_data_i = 32'h4444_4444;
    cycle();
    issue_valid_i = 1; issue_rd_i = 4;
    cycle();
    issue_valid_i = 0; rs2_i = 4; rs2_used_i = 1;
    cycle();
    flush_i = 1; issue_valid_i = 1; issue_rd_i = 6;
    cycle();
    flush_i = 0; issue_valid_i = 0;
    cycle();

    // x0 request: accepted, never written
    clear_inputs();
    alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h0000_1234;
    cycle(); cycle();

    // reset in the middle of a grant
    alu_valid_i = 1; alu_rd_i = 6; alu_data_i = 32'h6666_6666;
    issue_valid_i = 1; issue_rd_i = 12;
    cycle();
    issue_valid_i = 0;
    lnk_valid_i = 1; lnk_rd_i = 3;
    rst_ni = 0;
    #1;
    chk("midrst_rwr_en", rwr_en_o, 0);
    chk("midrst_lnk_ready", lnk_ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    @(posedge clk); #1;
    model_reset();
    clear_inputs();
    rst_ni = 1;
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid_i && $urandom_range(0, 1) == 1) begin
        alu_valid_i = 1; alu_rd_i = 5'($urandom_range(0, 31)); alu_data_i = $urandom;
      end
      if (!ld_valid_i && $urandom_range(0, 2) == 0) begin
        ld_valid_i = 1; ld_rd_i = 5'($urandom_range(0, 31)); ld_data_i = $urandom;
      end
      if (!lnk_valid_i && $urandom_range(0, 3) == 0) begin
        lnk_valid_i = 1; lnk_rd_i = 5'($urandom_range(0, 31)); lnk_data_i = $urandom;
      end
      issue_valid_i = ($urandom_range(0, 2) == 0);
      issue_rd_i    = 5'($urandom_range(0, 31));
      rs1_i         = 5'($urandom_range(0, 31));
      rs2_i         = 5'($urandom_range(0, 31));
      rs1_used_i    = $urandom_range(0, 1) == 1;
      rs2_used_i    = $urandom_range(0, 1) == 1;
      flush_i       = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
